// File: rtl/vx_multi_issue_sched_pkg.sv
// Shared types for the multi-issue warp scheduler.
// Selection policies understood by the per-group arbiters.
package vx_multi_issue_sched_pkg;

    typedef enum logic [1:0] {
        SCHED_LZC    = 2'd0,
        SCHED_RR     = 2'd1,
        SCHED_GREEDY = 2'd2
    } sched_policy_e;

endpackage

// File: rtl/vx_multi_issue_sched_group_select.sv
// Per-group warp arbiter: picks one ready warp of its group.
// Pointer holds the last selected wid (a global warp id).
module vx_multi_issue_sched_group_select
    import vx_multi_issue_sched_pkg::*;
#(
    parameter int            NUM_WARPS   = 16,
    parameter int            ISSUE_WIDTH = 2,
    parameter int            GROUP       = 0,
    parameter sched_policy_e POLICY      = SCHED_RR,
    localparam int           NW_WIDTH    = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_WARPS-1:0] ready,
    input  logic                 fire,
    output logic                 valid,
    output logic [NW_WIDTH-1:0]  wid
);

    logic [NUM_WARPS-1:0] cand;
    logic [NW_WIDTH-1:0]  ptr;

    // Restrict the ready set to warps owned by this group.
    always_comb begin
        cand = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            cand[w] = ready[w] && ((w % ISSUE_WIDTH) == GROUP);
        end
    end

    // Candidate search; later hits in each loop have higher priority.
    always_comb begin
        logic [NW_WIDTH-1:0] idx;
        valid = 1'b0;
        wid   = '0;
        idx   = '0;
        if (POLICY == SCHED_LZC) begin
            for (int k = NUM_WARPS - 1; k >= 0; k--) begin
                if (cand[k]) begin
                    valid = 1'b1;
                    wid   = NW_WIDTH'(k);
                end
            end
        end else begin
            // Search starts just past the pointer and wraps around.
            for (int k = NUM_WARPS; k >= 1; k--) begin
                idx = ptr + NW_WIDTH'(k);
                if (cand[idx]) begin
                    valid = 1'b1;
                    wid   = idx;
                end
            end
            if (POLICY == SCHED_GREEDY && cand[ptr]) begin
                valid = 1'b1;
                wid   = ptr;
            end
        end
    end

    // Remember the last issued warp of this group.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (fire) begin
            ptr <= wid;
        end
    end

endmodule

// File: rtl/vx_multi_issue_sched.sv
// Multi-issue warp scheduler: warp state, credits, issue slots.
// Warps are grouped by wid % ISSUE_WIDTH, one issue per group.
module vx_multi_issue_sched
    import vx_multi_issue_sched_pkg::*;
#(
    parameter int            NUM_WARPS   = 16,
    parameter int            NUM_THREADS = 4,
    parameter int            PC_BITS     = 30,
    parameter int            ISSUE_WIDTH = 2,
    parameter sched_policy_e POLICY      = SCHED_RR,
    parameter int            MAX_PENDING = 8,
    parameter int            PC_INCR     = 2,
    localparam int           NW_WIDTH    = $clog2(NUM_WARPS),
    localparam int           PND_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [PC_BITS-1:0]                     startup_pc,
    input  logic                                   spawn_valid,
    input  logic [NUM_WARPS-1:0]                   spawn_wmask,
    input  logic [PC_BITS-1:0]                     spawn_pc,
    input  logic                                   tmc_valid,
    input  logic [NW_WIDTH-1:0]                    tmc_wid,
    input  logic [NUM_THREADS-1:0]                 tmc_tmask,
    input  logic [ISSUE_WIDTH-1:0]                 br_valid,
    input  logic [ISSUE_WIDTH-1:0][NW_WIDTH-1:0]   br_wid,
    input  logic [ISSUE_WIDTH-1:0]                 br_taken,
    input  logic [ISSUE_WIDTH-1:0][PC_BITS-1:0]    br_dest,
    input  logic [ISSUE_WIDTH-1:0]                 unlock_valid,
    input  logic [ISSUE_WIDTH-1:0][NW_WIDTH-1:0]   unlock_wid,
    input  logic [NUM_WARPS-1:0]                   commit_mask,
    output logic [ISSUE_WIDTH-1:0]                 out_valid,
    input  logic [ISSUE_WIDTH-1:0]                 out_ready,
    output logic [ISSUE_WIDTH-1:0][NW_WIDTH-1:0]   out_wid,
    output logic [ISSUE_WIDTH-1:0][PC_BITS-1:0]    out_pc,
    output logic [ISSUE_WIDTH-1:0][NUM_THREADS-1:0] out_tmask,
    output logic [NUM_WARPS-1:0]                   active_warps,
    output logic                                   busy
);

    logic [NUM_WARPS-1:0]   active;
    logic [NUM_WARPS-1:0]   stalled;
    logic [NUM_THREADS-1:0] tmask   [NUM_WARPS];
    logic [PC_BITS-1:0]     pc      [NUM_WARPS];
    logic [PND_W-1:0]       pending [NUM_WARPS];

    logic [NUM_WARPS-1:0]   ready;
    logic [NUM_WARPS-1:0]   issue;
    logic                   pend_any;
    logic [ISSUE_WIDTH-1:0] sel_valid;
    logic [ISSUE_WIDTH-1:0] fire;
    logic [NW_WIDTH-1:0]    sel_wid [ISSUE_WIDTH];

    assign active_warps = active;

    // Readiness, per-warp issue strobes and credit activity.
    always_comb begin
        ready    = '0;
        issue    = '0;
        pend_any = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            ready[w] = active[w] && !stalled[w]
                    && (pending[w] < PND_W'(MAX_PENDING));
            issue[w] = fire[w % ISSUE_WIDTH]
                    && (sel_wid[w % ISSUE_WIDTH] == NW_WIDTH'(w));
            pend_any = pend_any || (pending[w] != '0);
        end
    end

    for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_grp
        vx_multi_issue_sched_group_select #(
            .NUM_WARPS   (NUM_WARPS),
            .ISSUE_WIDTH (ISSUE_WIDTH),
            .GROUP       (g),
            .POLICY      (POLICY)
        ) u_sel (
            .clk   (clk),
            .reset (reset),
            .ready (ready),
            .fire  (fire[g]),
            .valid (sel_valid[g]),
            .wid   (sel_wid[g])
        );
        assign fire[g] = sel_valid[g] && (!out_valid[g] || out_ready[g]);
    end

    // Warp state; later writes win: spawn, tmc, branch, unlock, issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active  <= NUM_WARPS'(1);
            stalled <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc[w]    <= '0;
                tmask[w] <= '0;
            end
            pc[0]    <= startup_pc;
            tmask[0] <= NUM_THREADS'(1);
        end else begin
            if (spawn_valid) begin
                for (int w = 0; w < NUM_WARPS; w++) begin
                    if (spawn_wmask[w] && !active[w]) begin
                        active[w]  <= 1'b1;
                        stalled[w] <= 1'b0;
                        pc[w]      <= spawn_pc;
                        tmask[w]   <= NUM_THREADS'(1);
                    end
                end
            end
            if (tmc_valid) begin
                active[tmc_wid]  <= (tmc_tmask != '0);
                tmask[tmc_wid]   <= tmc_tmask;
                stalled[tmc_wid] <= 1'b0;
            end
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                if (br_valid[i]) begin
                    if (br_taken[i]) pc[br_wid[i]] <= br_dest[i];
                    stalled[br_wid[i]] <= 1'b0;
                end
            end
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                if (unlock_valid[i]) stalled[unlock_wid[i]] <= 1'b0;
            end
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (issue[w]) begin
                    stalled[w] <= 1'b1;
                    pc[w]      <= pc[w] + PC_BITS'(PC_INCR);
                end
            end
        end
    end

    // In-flight credits: +1 on issue, -1 on commit, both cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) pending[w] <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (issue[w] && !commit_mask[w]) begin
                    pending[w] <= pending[w] + PND_W'(1);
                end else if (!issue[w] && commit_mask[w]) begin
                    pending[w] <= pending[w] - PND_W'(1);
                end
            end
        end
    end

    // Issue slot registers hold until fetch accepts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= '0;
            out_wid   <= '0;
            out_pc    <= '0;
            out_tmask <= '0;
        end else begin
            for (int g = 0; g < ISSUE_WIDTH; g++) begin
                if (fire[g]) begin
                    out_valid[g] <= 1'b1;
                    out_wid[g]   <= sel_wid[g];
                    out_pc[g]    <= pc[sel_wid[g]];
                    out_tmask[g] <= tmask[sel_wid[g]];
                end else if (out_ready[g]) begin
                    out_valid[g] <= 1'b0;
                end
            end
        end
    end

    // Registered core-busy indication.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
        end else begin
            busy <= (|active) || pend_any || (|out_valid);
        end
    end

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_chk
        a_no_underflow : assert property (@(posedge clk) disable iff (reset)
            !(commit_mask[w] && pending[w] == '0));
        a_no_overflow : assert property (@(posedge clk) disable iff (reset)
            !(issue[w] && pending[w] == PND_W'(MAX_PENDING)));
    end

endmodule

// File: tb/tb_vx_multi_issue_sched.sv
// Directed bench for the multi-issue warp scheduler.
// Instance 0: round-robin, 1: greedy, 2: round-robin with 2 credits.
module tb_vx_multi_issue_sched;
    import vx_multi_issue_sched_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [29:0]          startup_pc;
    logic                 spawn_valid;
    logic [15:0]          spawn_wmask;
    logic [29:0]          spawn_pc;
    logic                 tmc_valid;
    logic [3:0]           tmc_wid;
    logic [3:0]           tmc_tmask;
    logic [1:0]           br_valid;
    logic [1:0][3:0]      br_wid;
    logic [1:0]           br_taken;
    logic [1:0][29:0]     br_dest;
    logic [1:0]           unlock_valid;
    logic [1:0][3:0]      unlock_wid;
    logic [15:0]          commit_mask;
    logic [1:0]           out_ready;

    logic [1:0]           ov   [3];
    logic [1:0][3:0]      owid [3];
    logic [1:0][29:0]     opc  [3];
    logic [1:0][3:0]      otm  [3];
    logic [15:0]          act  [3];
    logic                 bsy  [3];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        vx_multi_issue_sched #(
            .NUM_WARPS   (16),
            .NUM_THREADS (4),
            .PC_BITS     (30),
            .ISSUE_WIDTH (2),
            .POLICY      (i == 1 ? SCHED_GREEDY : SCHED_RR),
            .MAX_PENDING (i == 2 ? 2 : 8),
            .PC_INCR     (2)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .startup_pc   (startup_pc),
            .spawn_valid  (spawn_valid),
            .spawn_wmask  (spawn_wmask),
            .spawn_pc     (spawn_pc),
            .tmc_valid    (tmc_valid),
            .tmc_wid      (tmc_wid),
            .tmc_tmask    (tmc_tmask),
            .br_valid     (br_valid),
            .br_wid       (br_wid),
            .br_taken     (br_taken),
            .br_dest      (br_dest),
            .unlock_valid (unlock_valid),
            .unlock_wid   (unlock_wid),
            .commit_mask  (commit_mask),
            .out_valid    (ov[i]),
            .out_ready    (out_ready),
            .out_wid      (owid[i]),
            .out_pc       (opc[i]),
            .out_tmask    (otm[i]),
            .active_warps (act[i]),
            .busy         (bsy[i])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        spawn_valid  = 1'b0;
        spawn_wmask  = '0;
        spawn_pc     = '0;
        tmc_valid    = 1'b0;
        tmc_wid      = '0;
        tmc_tmask    = '0;
        br_valid     = '0;
        br_wid       = '0;
        br_taken     = '0;
        br_dest      = '0;
        unlock_valid = '0;
        unlock_wid   = '0;
        commit_mask  = '0;
    endtask

    task automatic unlock(input int lane, input logic [3:0] w);
        unlock_valid[lane] = 1'b1;
        unlock_wid[lane]   = w;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr();
        out_ready = 2'b11;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int rr_seq [9] = '{1, 3, 5, 7, 9, 11, 13, 15, 1};

    initial begin
        startup_pc = 30'h100;
        clr();
        out_ready = 2'b11;
        tick();
        tick();
        chk("rst_valid", ov[0], 0);
        chk("rst_busy", bsy[0], 0);
        chk("rst_active", act[0], 16'h0001);

        // first issue, unlock latency, credit limit
        reset = 1'b0;
        tick();
        chk("t1_valid", ov[0][0], 1);
        chk("t1_wid", owid[0][0], 0);
        chk("t1_pc", opc[0][0], 'h100);
        chk("t1_tmask", otm[0][0], 1);
        chk("t1_busy", bsy[0], 1);
        tick();
        chk("t1_noreissue", ov[0][0], 0);
        unlock(0, 0);
        tick();
        clr();
        chk("t1_unlock_lat", ov[0][0], 0);
        tick();
        chk("t1_valid2", ov[0][0], 1);
        chk("t1_pc2", opc[0][0], 'h102);
        unlock(0, 0);
        tick();
        clr();
        tick();
        chk("t1_pc3", opc[0][0], 'h104);
        chk("mp_stop", ov[2][0], 0);
        commit_mask = 16'h0001;
        tick();
        clr();
        chk("mp_commit_lat", ov[2][0], 0);
        tick();
        chk("mp_one_more", ov[2][0], 1);
        chk("mp_one_more_pc", opc[2][0], 'h104);
        unlock(0, 0);
        tick();
        clr();
        chk("mp_stop2a", ov[2][0], 0);
        tick();
        chk("mp_stop2b", ov[2][0], 0);
        chk("t1_pc4", opc[0][0], 'h106);
        tick();
        chk("mp_stop2c", ov[2][0], 0);

        // round-robin across group 1
        do_reset();
        spawn_valid = 1'b1;
        spawn_wmask = 16'hFFFF;
        spawn_pc    = 30'h200;
        tick();
        clr();
        chk("t2_active", act[0], 16'hFFFF);
        for (int k = 0; k < 9; k++) begin
            tick();
            clr();
            chk($sformatf("t2_valid%0d", k), ov[0][1], 1);
            chk($sformatf("t2_wid%0d", k), owid[0][1], rr_seq[k]);
            if (k == 0) chk("t2_pc_first", opc[0][1], 'h200);
            if (k == 8) chk("t2_pc_again", opc[0][1], 'h202);
            unlock(1, 4'(rr_seq[k]));
        end
        clr();

        // greedy versus round-robin after a fetch stall
        do_reset();
        spawn_valid = 1'b1;
        spawn_wmask = 16'h0014;
        spawn_pc    = 30'h300;
        tick();
        clr();
        tick();
        chk("t3_rr_first", owid[0][0], 2);
        chk("t3_gr_first", owid[1][0], 2);
        chk("t3_gr_pc", opc[1][0], 'h300);
        out_ready = 2'b10;
        unlock(0, 2);
        tick();
        clr();
        chk("t3_hold_valid", ov[1][0], 1);
        chk("t3_hold_wid", owid[1][0], 2);
        tick();
        chk("t3_hold_pc", opc[1][0], 'h300);
        out_ready = 2'b11;
        tick();
        chk("t3_rr_moves", owid[0][0], 4);
        chk("t3_rr_pc", opc[0][0], 'h300);
        chk("t3_gr_stays", owid[1][0], 2);
        chk("t3_gr_stays_pc", opc[1][0], 'h302);
        tmc_valid = 1'b1;
        tmc_wid   = 4'd2;
        tmc_tmask = 4'd0;
        tick();
        clr();
        chk("t3_gr_next", owid[1][0], 4);
        chk("t3_gr_active", act[1], 16'h0011);
        chk("t3_rr_back", owid[0][0], 2);
        chk("t3_rr_back_pc", opc[0][0], 'h302);

        // fetch backpressure then branch redirect
        do_reset();
        tick();
        out_ready = 2'b00;
        unlock(0, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            clr();
            chk($sformatf("t5_hold_v%0d", k), ov[0][0], 1);
            chk($sformatf("t5_hold_pc%0d", k), opc[0][0], 'h100);
        end
        br_valid[0] = 1'b1;
        br_wid[0]   = 4'd0;
        br_taken[0] = 1'b1;
        br_dest[0]  = 30'h40;
        tick();
        clr();
        chk("t5_br_hold", opc[0][0], 'h100);
        out_ready = 2'b11;
        tick();
        chk("t5_br_wid", owid[0][0], 0);
        chk("t5_br_pc", opc[0][0], 'h40);

        // tmc and branch on the same warp, then async reset
        do_reset();
        spawn_valid = 1'b1;
        spawn_wmask = 16'h0008;
        spawn_pc    = 30'h500;
        tick();
        clr();
        tick();
        chk("t6_valid", ov[0][1], 1);
        chk("t6_wid", owid[0][1], 3);
        chk("t6_pc", opc[0][1], 'h500);
        tmc_valid   = 1'b1;
        tmc_wid     = 4'd3;
        tmc_tmask   = 4'd0;
        br_valid[1] = 1'b1;
        br_wid[1]   = 4'd3;
        br_taken[1] = 1'b1;
        br_dest[1]  = 30'h80;
        tick();
        clr();
        chk("t6_inactive", act[0], 16'h0001);
        chk("t6_no_issue", ov[0][1], 0);
        tmc_valid = 1'b1;
        tmc_wid   = 4'd3;
        tmc_tmask = 4'd3;
        tick();
        clr();
        tick();
        chk("t6_re_wid", owid[0][1], 3);
        chk("t6_re_pc", opc[0][1], 'h80);
        chk("t6_re_tmask", otm[0][1], 3);
        out_ready = 2'b00;
        tick();
        chk("t6_stall_valid", ov[0][1], 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", ov[0], 0);
        chk("t6_rst_busy", bsy[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
